// File: rtl/alu_rs_if.sv
// Bundles the dispatch, result-broadcast and issue signals of the ALU reservation station.
// The slave modport is the station's view; the master modport is the surrounding pipeline's view.
interface alu_rs_if #(
    parameter int XLEN           = 32,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int ROB_SIZE_WIDTH = 4
);
    logic                      flush;

    logic                      dec_valid;
    logic [ALU_OP_WIDTH-1:0]   dec_op;
    logic [XLEN-1:0]           dec_vj;
    logic [XLEN-1:0]           dec_vk;
    logic                      dec_j_pending;
    logic                      dec_k_pending;
    logic [ROB_SIZE_WIDTH-1:0] dec_qj;
    logic [ROB_SIZE_WIDTH-1:0] dec_qk;
    logic [ROB_SIZE_WIDTH-1:0] dec_id;
    logic                      rs_full;

    logic                      alu_ready;
    logic [XLEN-1:0]           alu_res;
    logic [ROB_SIZE_WIDTH-1:0] alu_id;
    logic                      lsb_ready;
    logic [XLEN-1:0]           lsb_res;
    logic [ROB_SIZE_WIDTH-1:0] lsb_id;

    logic                      rs_ready;
    logic [ALU_OP_WIDTH-1:0]   rs_op;
    logic [XLEN-1:0]           rs_val1;
    logic [XLEN-1:0]           rs_val2;
    logic [ROB_SIZE_WIDTH-1:0] rs_id;

    modport slave (
        input  flush,
        input  dec_valid, dec_op, dec_vj, dec_vk, dec_j_pending, dec_k_pending,
        input  dec_qj, dec_qk, dec_id,
        output rs_full,
        input  alu_ready, alu_res, alu_id, lsb_ready, lsb_res, lsb_id,
        output rs_ready, rs_op, rs_val1, rs_val2, rs_id
    );

    modport master (
        output flush,
        output dec_valid, dec_op, dec_vj, dec_vk, dec_j_pending, dec_k_pending,
        output dec_qj, dec_qk, dec_id,
        input  rs_full,
        output alu_ready, alu_res, alu_id, lsb_ready, lsb_res, lsb_id,
        input  rs_ready, rs_op, rs_val1, rs_val2, rs_id
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU ops until both operands are known,
// snoops the ALU/LSB result broadcasts, and issues the lowest-index ready entry each cycle.
module alu_rs #(
    parameter int RS_SIZE_WIDTH  = 3,
    parameter int XLEN           = 32,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int ROB_SIZE_WIDTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    alu_rs_if.slave bus
);
    localparam int RS_SIZE = 1 << RS_SIZE_WIDTH;

    typedef struct packed {
        logic            pend;
        logic [XLEN-1:0] val;
    } opnd_t;

    logic [RS_SIZE-1:0]        busy_q,   busy_d;
    logic [RS_SIZE-1:0]        j_pend_q, j_pend_d;
    logic [RS_SIZE-1:0]        k_pend_q, k_pend_d;
    logic [ALU_OP_WIDTH-1:0]   op_q [RS_SIZE];
    logic [ALU_OP_WIDTH-1:0]   op_d [RS_SIZE];
    logic [XLEN-1:0]           vj_q [RS_SIZE];
    logic [XLEN-1:0]           vj_d [RS_SIZE];
    logic [XLEN-1:0]           vk_q [RS_SIZE];
    logic [XLEN-1:0]           vk_d [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] qj_q [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] qj_d [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] qk_q [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] qk_d [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] id_q [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] id_d [RS_SIZE];

    logic [RS_SIZE-1:0]        cand_s;
    logic [RS_SIZE-1:0]        free_s;
    logic [RS_SIZE_WIDTH-1:0]  sel_idx_s;
    logic [RS_SIZE_WIDTH-1:0]  free_idx_s;
    logic                      rs_full_s;
    logic                      issue_s;
    logic                      insert_s;

    function automatic logic [RS_SIZE_WIDTH-1:0] lowest_idx(input logic [RS_SIZE-1:0] vec);
        logic [RS_SIZE_WIDTH-1:0] idx;
        idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = RS_SIZE_WIDTH'(i);
            end
        end
        return idx;
    endfunction

    // ALU result takes priority over LSB when both carry the awaited tag.
    function automatic opnd_t snoop(
        input logic                      en,
        input logic                      pend,
        input logic [ROB_SIZE_WIDTH-1:0] q,
        input logic [XLEN-1:0]           val,
        input logic                      a_rdy,
        input logic [ROB_SIZE_WIDTH-1:0] a_id,
        input logic [XLEN-1:0]           a_res,
        input logic                      l_rdy,
        input logic [ROB_SIZE_WIDTH-1:0] l_id,
        input logic [XLEN-1:0]           l_res
    );
        opnd_t r;
        if (en && pend && a_rdy && (a_id == q)) begin
            r.pend = 1'b0;
            r.val  = a_res;
        end else if (en && pend && l_rdy && (l_id == q)) begin
            r.pend = 1'b0;
            r.val  = l_res;
        end else begin
            r.pend = pend;
            r.val  = val;
        end
        return r;
    endfunction

    assign cand_s     = busy_q & ~j_pend_q & ~k_pend_q;
    assign free_s     = ~busy_q;
    assign sel_idx_s  = lowest_idx(cand_s);
    assign free_idx_s = lowest_idx(free_s);
    assign rs_full_s  = &busy_q;
    assign issue_s    = (|cand_s) && !bus.flush;
    assign insert_s   = bus.dec_valid && !rs_full_s && !bus.flush;

    assign bus.rs_full  = rs_full_s;
    assign bus.rs_ready = issue_s;
    assign bus.rs_op    = issue_s ? op_q[sel_idx_s] : '0;
    assign bus.rs_val1  = issue_s ? vj_q[sel_idx_s] : '0;
    assign bus.rs_val2  = issue_s ? vk_q[sel_idx_s] : '0;
    assign bus.rs_id    = issue_s ? id_q[sel_idx_s] : '0;

    // Next-state per entry: insert into the lowest free slot, otherwise snoop; issue and flush free slots.
    always_comb begin
        busy_d   = busy_q;
        j_pend_d = j_pend_q;
        k_pend_d = k_pend_q;
        op_d     = op_q;
        vj_d     = vj_q;
        vk_d     = vk_q;
        qj_d     = qj_q;
        qk_d     = qk_q;
        id_d     = id_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            logic ins_here;
            logic iss_here;
            ins_here = insert_s && (free_idx_s == RS_SIZE_WIDTH'(i));
            iss_here = issue_s && (sel_idx_s == RS_SIZE_WIDTH'(i));
            busy_d[i] = (ins_here | (busy_q[i] & ~iss_here)) & ~bus.flush;
            {j_pend_d[i], vj_d[i]} = ins_here
                ? snoop(1'b1, bus.dec_j_pending, bus.dec_qj, bus.dec_vj,
                        bus.alu_ready, bus.alu_id, bus.alu_res,
                        bus.lsb_ready, bus.lsb_id, bus.lsb_res)
                : snoop(busy_q[i] & ~bus.flush, j_pend_q[i], qj_q[i], vj_q[i],
                        bus.alu_ready, bus.alu_id, bus.alu_res,
                        bus.lsb_ready, bus.lsb_id, bus.lsb_res);
            {k_pend_d[i], vk_d[i]} = ins_here
                ? snoop(1'b1, bus.dec_k_pending, bus.dec_qk, bus.dec_vk,
                        bus.alu_ready, bus.alu_id, bus.alu_res,
                        bus.lsb_ready, bus.lsb_id, bus.lsb_res)
                : snoop(busy_q[i] & ~bus.flush, k_pend_q[i], qk_q[i], vk_q[i],
                        bus.alu_ready, bus.alu_id, bus.alu_res,
                        bus.lsb_ready, bus.lsb_id, bus.lsb_res);
            op_d[i] = ins_here ? bus.dec_op : op_q[i];
            qj_d[i] = ins_here ? bus.dec_qj : qj_q[i];
            qk_d[i] = ins_here ? bus.dec_qk : qk_q[i];
            id_d[i] = ins_here ? bus.dec_id : id_q[i];
        end
    end

    // Entry storage with asynchronous clear of every field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            j_pend_q <= '0;
            k_pend_q <= '0;
            op_q     <= '{default: '0};
            vj_q     <= '{default: '0};
            vk_q     <= '{default: '0};
            qj_q     <= '{default: '0};
            qk_q     <= '{default: '0};
            id_q     <= '{default: '0};
        end else begin
            busy_q   <= busy_d;
            j_pend_q <= j_pend_d;
            k_pend_q <= k_pend_d;
            op_q     <= op_d;
            vj_q     <= vj_d;
            vk_q     <= vk_d;
            qj_q     <= qj_d;
            qk_q     <= qk_d;
            id_q     <= id_d;
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: issued instructions are checked in order against a scoreboard
// queue filled at dispatch time; timing-specific points are checked directly.
module tb_alu_rs;
    localparam int XLEN = 32;
    localparam int OPW  = 4;
    localparam int RW   = 4;
    localparam logic [OPW-1:0] OP_ADD = 4'd1;
    localparam logic [OPW-1:0] OP_SUB = 4'd2;
    localparam logic [OPW-1:0] OP_AND = 4'd3;

    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] v1;
        logic [XLEN-1:0] v2;
        logic [RW-1:0]   id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_rs_if #(.XLEN(XLEN), .ALU_OP_WIDTH(OPW), .ROB_SIZE_WIDTH(RW)) bus ();

    alu_rs #(
        .RS_SIZE_WIDTH(3), .XLEN(XLEN), .ALU_OP_WIDTH(OPW), .ROB_SIZE_WIDTH(RW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush         = 1'b0;
        bus.dec_valid     = 1'b0;
        bus.dec_op        = '0;
        bus.dec_vj        = '0;
        bus.dec_vk        = '0;
        bus.dec_j_pending = 1'b0;
        bus.dec_k_pending = 1'b0;
        bus.dec_qj        = '0;
        bus.dec_qk        = '0;
        bus.dec_id        = '0;
        bus.alu_ready     = 1'b0;
        bus.alu_res       = '0;
        bus.alu_id        = '0;
        bus.lsb_ready     = 1'b0;
        bus.lsb_res       = '0;
        bus.lsb_id        = '0;
    endtask

    task automatic drive_dec(input logic [OPW-1:0] op, input logic [XLEN-1:0] vj,
                             input logic [XLEN-1:0] vk, input logic jp, input logic kp,
                             input logic [RW-1:0] qj, input logic [RW-1:0] qk,
                             input logic [RW-1:0] id);
        bus.dec_valid     = 1'b1;
        bus.dec_op        = op;
        bus.dec_vj        = vj;
        bus.dec_vk        = vk;
        bus.dec_j_pending = jp;
        bus.dec_k_pending = kp;
        bus.dec_qj        = qj;
        bus.dec_qk        = qk;
        bus.dec_id        = id;
    endtask

    task automatic push_exp(input logic [OPW-1:0] op, input logic [XLEN-1:0] v1,
                            input logic [XLEN-1:0] v2, input logic [RW-1:0] id);
        exp_t e;
        e.op = op;
        e.v1 = v1;
        e.v2 = v2;
        e.id = id;
        sb_q.push_back(e);
    endtask

    // Every issue seen on the bus must be the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.rs_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_issue", {63'd0, bus.rs_ready}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("issue_op",   {60'd0, bus.rs_op},   {60'd0, mon_e.op});
                chk("issue_val1", {32'd0, bus.rs_val1}, {32'd0, mon_e.v1});
                chk("issue_val2", {32'd0, bus.rs_val2}, {32'd0, mon_e.v2});
                chk("issue_id",   {60'd0, bus.rs_id},   {60'd0, mon_e.id});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_full",  {63'd0, bus.rs_full},  64'd0);
        chk("reset_ready", {63'd0, bus.rs_ready}, 64'd0);

        // Reset mid-run: seven entries waiting on an unused tag plus one ready entry.
        tick();
        for (int i = 0; i < 7; i++) begin
            drive_dec(OP_ADD, 32'(i + 1), 32'd0, 1'b0, 1'b1, 4'd0, 4'd15, 4'(i));
            tick();
        end
        drive_dec(OP_AND, 32'h0000_000A, 32'h0000_000B, 1'b0, 1'b0, 4'd0, 4'd0, 4'd7);
        tick();
        idle();
        #1;
        chk("prereset_ready", {63'd0, bus.rs_ready}, 64'd1);
        chk("prereset_full",  {63'd0, bus.rs_full},  64'd1);
        rst_n = 1'b0;
        #1;
        chk("inreset_ready", {63'd0, bus.rs_ready}, 64'd0);
        chk("inreset_full",  {63'd0, bus.rs_full},  64'd0);
        chk("inreset_op",    {60'd0, bus.rs_op},    64'd0);
        chk("inreset_val1",  {32'd0, bus.rs_val1},  64'd0);
        chk("inreset_val2",  {32'd0, bus.rs_val2},  64'd0);
        chk("inreset_id",    {60'd0, bus.rs_id},    64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("postreset_full",  {63'd0, bus.rs_full},  64'd0);
        chk("postreset_ready", {63'd0, bus.rs_ready}, 64'd0);

        // Ready insert issues in the very next cycle, then goes quiet.
        tick();
        drive_dec(OP_ADD, 32'd5, 32'd7, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3);
        push_exp(OP_ADD, 32'd5, 32'd7, 4'd3);
        tick();
        idle();
        @(negedge clk);
        chk("ready_insert_issue", {63'd0, bus.rs_ready}, 64'd1);
        tick();
        @(negedge clk);
        chk("ready_insert_idle", {63'd0, bus.rs_ready}, 64'd0);

        // Wakeup with both broadcasts on the same tag: ALU value must win.
        tick();
        drive_dec(OP_SUB, 32'hDEAD_0000, 32'd2, 1'b1, 1'b0, 4'd4, 4'd0, 4'd6);
        push_exp(OP_SUB, 32'h0000_0010, 32'd2, 4'd6);
        tick();
        idle();
        tick();
        bus.alu_ready = 1'b1; bus.alu_id = 4'd4; bus.alu_res = 32'h0000_0010;
        bus.lsb_ready = 1'b1; bus.lsb_id = 4'd4; bus.lsb_res = 32'h0000_0099;
        @(negedge clk);
        chk("wakeup_wait", {63'd0, bus.rs_ready}, 64'd1 ^ 64'd1);
        tick();
        idle();
        @(negedge clk);
        chk("wakeup_issue", {63'd0, bus.rs_ready}, 64'd1);

        // Insert-time forwarding from LSB, with a non-matching ALU broadcast ignored.
        tick();
        drive_dec(OP_ADD, 32'd3, 32'h0000_BEEF, 1'b0, 1'b1, 4'd0, 4'd2, 4'd9);
        bus.lsb_ready = 1'b1; bus.lsb_id = 4'd2; bus.lsb_res = 32'd9;
        bus.alu_ready = 1'b1; bus.alu_id = 4'd5; bus.alu_res = 32'h0000_0055;
        push_exp(OP_ADD, 32'd3, 32'd9, 4'd9);
        tick();
        idle();
        @(negedge clk);
        chk("fwd_lsb_issue", {63'd0, bus.rs_ready}, 64'd1);

        // Insert-time forwarding with both broadcasts matching: ALU wins.
        tick();
        drive_dec(OP_AND, 32'h0000_DEAD, 32'd4, 1'b1, 1'b0, 4'd2, 4'd0, 4'd10);
        bus.alu_ready = 1'b1; bus.alu_id = 4'd2; bus.alu_res = 32'h0000_0021;
        bus.lsb_ready = 1'b1; bus.lsb_id = 4'd2; bus.lsb_res = 32'h0000_0012;
        push_exp(OP_AND, 32'h0000_0021, 32'd4, 4'd10);
        tick();
        idle();
        @(negedge clk);
        chk("fwd_both_issue", {63'd0, bus.rs_ready}, 64'd1);

        // Fill all eight entries pending on tag 1, drop a ninth, then drain in index order.
        tick();
        for (int i = 0; i < 8; i++) begin
            drive_dec(OP_ADD, 32'(100 + i), 32'd0, 1'b0, 1'b1, 4'd0, 4'd1, 4'(i));
            push_exp(OP_ADD, 32'(100 + i), 32'h0000_0077, 4'(i));
            tick();
        end
        drive_dec(OP_SUB, 32'd1, 32'd1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd15);
        @(negedge clk);
        chk("full_set",      {63'd0, bus.rs_full},  64'd1);
        chk("full_no_issue", {63'd0, bus.rs_ready}, 64'd0);
        tick();
        idle();
        bus.alu_ready = 1'b1; bus.alu_id = 4'd1; bus.alu_res = 32'h0000_0077;
        bus.lsb_ready = 1'b1; bus.lsb_id = 4'd1; bus.lsb_res = 32'h0000_0066;
        tick();
        idle();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("drain_ready", {63'd0, bus.rs_ready}, 64'd1);
            if (i == 0) chk("full_hold", {63'd0, bus.rs_full}, 64'd1);
            if (i == 1) chk("full_drop", {63'd0, bus.rs_full}, 64'd0);
        end
        @(negedge clk);
        chk("drain_done", {63'd0, bus.rs_ready}, 64'd0);

        // Flush with four busy entries (last one ready) and a simultaneous dispatch.
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_dec(OP_ADD, 32'(i), 32'd0, 1'b0, 1'b1, 4'd0, 4'd9, 4'(i));
            tick();
        end
        drive_dec(OP_ADD, 32'd1, 32'd1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd12);
        tick();
        bus.flush = 1'b1;
        drive_dec(OP_SUB, 32'd2, 32'd2, 1'b0, 1'b0, 4'd0, 4'd0, 4'd13);
        @(negedge clk);
        chk("flush_ready", {63'd0, bus.rs_ready}, 64'd0);
        tick();
        idle();
        @(negedge clk);
        chk("postflush_full",  {63'd0, bus.rs_full},  64'd0);
        chk("postflush_ready", {63'd0, bus.rs_ready}, 64'd0);
        tick();
        bus.alu_ready = 1'b1; bus.alu_id = 4'd9; bus.alu_res = 32'h0000_0042;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postflush_quiet", {63'd0, bus.rs_ready}, 64'd0);
        end

        // A fresh insert after flush issues normally from entry 0.
        tick();
        drive_dec(OP_SUB, 32'd8, 32'd9, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1);
        push_exp(OP_SUB, 32'd8, 32'd9, 4'd1);
        tick();
        idle();
        @(negedge clk);
        chk("refill_issue", {63'd0, bus.rs_ready}, 64'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
